cic_comb: RTL and testbench
===========================

// Module: cic_comb
// PURPOSE
//  Comb section of the CIC decimator: N cascaded y[n] = x[n] - x[n-M] stages running at the
//  decimated rate. Sits directly downstream of decimate, consuming its data_out/data_out_ready
//  strobe pair, and feeds the compensation-FIR/output path. Modular two's-complement arithmetic,
//  then round-half-up with saturation to the output width.
// PARAMETERS
//  DATA_IN_BITS      17  signed input width = integrator/decimator width; internal comb width
//  DATA_OUT_BITS     17  signed output width; must be <= DATA_IN_BITS
//  NUM_STAGES        4   number of comb stages N (>=1)
//  DIFF_DELAY        1   differential delay M per stage (1 or 2)
//  SUPPRESS_PRIME    1   1: drop first NUM_STAGES*DIFF_DELAY outputs after reset (transient)
// PORTS
//  clk             in   1              single clock; all logic posedge
//  rst             in   1              synchronous, active-low reset
//  data_in_ready   in   1              one-cycle strobe: data_in valid (from decimate)
//  data_in         in   DATA_IN_BITS   signed decimated sample
//  data_out_ready  out  1              one-cycle strobe: data_out valid
//  data_out        out  DATA_OUT_BITS  signed filtered, rounded, saturated sample
//  primed          out  1              high once NUM_STAGES*DIFF_DELAY samples accepted
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all delay lines, stage regs, valid pipe, prime counter -> 0;
//    data_out_ready=0, data_out=0, primed=0. Takes effect mid-operation; in-flight samples lost.
//  - No backpressure. A strobe may arrive every cycle (back-to-back) and must be accepted;
//    throughput 1 sample/cycle even though decimate strobes at most 1 per DECIMATION_NUM.
//  - Valid pipe v[0..N]: v[0]=data_in_ready registered with data_in. Stage k computes only when
//    v[k-1] is high: d_k <= x - dl_k[M-1]; dl_k shifts in x. Delay lines never move without valid.
//  - Arithmetic: width DATA_IN_BITS, wrap on overflow (no saturation inside combs; CIC relies on it).
//  - Output stage (on v[N]): SHIFT = DATA_IN_BITS-DATA_OUT_BITS. If SHIFT==0 pass through.
//    Else r = (d_N + 2^(SHIFT-1)) >>> SHIFT, computed at DATA_IN_BITS+1 bits; if r > max positive
//    of DATA_OUT_BITS, clamp to 2^(DATA_OUT_BITS-1)-1. Negative side cannot overflow.
//  - Latency: data_in_ready at cycle t -> data_out_ready at cycle t+NUM_STAGES+2 (input reg,
//    N stage regs, output reg). Fixed, independent of strobe spacing.
//  - Prime counter: counts accepted inputs, saturates at NUM_STAGES*DIFF_DELAY; primed=1 at
//    saturation. With SUPPRESS_PRIME=1, data_out_ready is gated off for outputs whose input was
//    accepted while count < NUM_STAGES*DIFF_DELAY (gate bit travels in the valid pipe, not
//    sampled at output time). data_out still updates when gated.
//  - data_out holds last value between strobes; data_out_ready high exactly one cycle per output.
//  - Strobe coincident with reset deassertion edge: rst sampled low wins; sample dropped.
// STRUCTURE
//  - rmx_pkg: typedef signed sample types per width, function round_sat(), shared
//    DATA_IN_BITS/DATA_OUT_BITS defaults used by decimate and cic_comb.
//  - Sub-module comb_stage (WIDTH, DIFF_DELAY): in_valid, x, out_valid, y, one register stage +
//    M-deep delay line; cic_comb generates NUM_STAGES of them plus input reg, prime counter, round/sat.
// TESTING
//  1 Impulse, N=4 M=1 SUPPRESS_PRIME=0 17->17: 1 then zeros, spaced 32 cycles -> outputs
//    1,-4,6,-4,1,0,0..., each strobe exactly 6 cycles after input strobe.
//  2 Step, defaults: constant 100 every 32 cycles -> first 4 outputs suppressed, primed rises on
//    4th input, all emitted outputs 0.
//  3 Wrap, N=1 M=1: inputs 65535 then -65536 -> outputs 65535 then 1 (17-bit modular -131071).
//  4 Round/sat, N=1 20->17, SUPPRESS=0: inputs 0 then 0x7FFFF -> 65535 (saturated); inputs 0,
//    then 12 -> 2 (12/8=1.5 rounds up); -12 -> -1.
//  5 Back-to-back strobes every cycle, impulse as in 1 -> same 1,-4,6,-4,1 on consecutive cycles.
//  6 Reset mid-stream: rst low 1 cycle with samples in flight -> no output strobes for
//    in-flight data, primed=0, next impulse reproduces scenario 1/2 from scratch.

Source files
------------

// File: rtl/rmx_pkg.sv
// Shared sample types, default widths and the round-half-up/saturate helper
// used by the decimator and the CIC comb section.
package rmx_pkg;

    localparam int unsigned DATA_IN_BITS_DEF  = 17;
    localparam int unsigned DATA_OUT_BITS_DEF = 17;
    localparam int unsigned CALC_BITS         = 64;

    typedef logic signed [DATA_IN_BITS_DEF-1:0]  sample_in_t;
    typedef logic signed [DATA_OUT_BITS_DEF-1:0] sample_out_t;
    typedef logic signed [CALC_BITS-1:0]         calc_t;

    // Wide signed arithmetic stands in for the (in+1)-bit datapath; results are
    // identical because the sign-extended operand never overflows 64 bits.
    function automatic calc_t round_sat(input calc_t d, input int unsigned shift,
                                        input int unsigned out_bits);
        calc_t half;
        calc_t r;
        calc_t max_pos;
        half    = (shift == 0) ? calc_t'(0) : (calc_t'(1) <<< (shift - 1));
        r       = (d + half) >>> shift;
        max_pos = (calc_t'(1) <<< (out_bits - 1)) - calc_t'(1);
        if (r > max_pos)
            r = max_pos;
        return r;
    endfunction

endpackage

// File: rtl/comb_stage.sv
// One CIC comb stage: y <= x - x[n-M], advancing only on valid input.
module comb_stage #(
    parameter int unsigned WIDTH      = 17,
    parameter int unsigned DIFF_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] dl [DIFF_DELAY];

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            for (int unsigned i = 0; i < DIFF_DELAY; i++)
                dl[i] <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                // Modular subtraction: wrap is intended, the CIC relies on it.
                y     <= x - dl[DIFF_DELAY-1];
                dl[0] <= x;
                for (int unsigned i = 1; i < DIFF_DELAY; i++)
                    dl[i] <= dl[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_comb.sv
// CIC decimator comb section: input register, NUM_STAGES comb stages, prime
// tracking and a rounding/saturating output register.
module cic_comb
    import rmx_pkg::*;
#(
    parameter int unsigned DATA_IN_BITS   = DATA_IN_BITS_DEF,
    parameter int unsigned DATA_OUT_BITS  = DATA_OUT_BITS_DEF,
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned DIFF_DELAY     = 1,
    parameter int unsigned SUPPRESS_PRIME = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_in_ready,
    input  logic [DATA_IN_BITS-1:0]  data_in,
    output logic                     data_out_ready,
    output logic [DATA_OUT_BITS-1:0] data_out,
    output logic                     primed
);

    localparam int unsigned SHIFT       = DATA_IN_BITS - DATA_OUT_BITS;
    localparam int unsigned PRIME_COUNT = NUM_STAGES * DIFF_DELAY;
    localparam int unsigned CNT_BITS    = $clog2(PRIME_COUNT + 1);

    logic [DATA_IN_BITS-1:0]  x [NUM_STAGES+1];
    logic                     v [NUM_STAGES+1];
    logic [NUM_STAGES:0]      gate_pipe;
    logic [CNT_BITS-1:0]      prime_cnt;
    logic [DATA_OUT_BITS-1:0] data_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v[0]      <= 1'b0;
            x[0]      <= '0;
            gate_pipe <= '0;
            prime_cnt <= '0;
        end else begin
            v[0] <= data_in_ready;
            if (data_in_ready)
                x[0] <= data_in;
            // Gate bit is captured at accept time and rides alongside the valid pipe.
            gate_pipe[0]            <= data_in_ready && (prime_cnt < CNT_BITS'(PRIME_COUNT));
            gate_pipe[NUM_STAGES:1] <= gate_pipe[NUM_STAGES-1:0];
            if (data_in_ready && (prime_cnt != CNT_BITS'(PRIME_COUNT)))
                prime_cnt <= prime_cnt + CNT_BITS'(1);
        end
    end

    assign primed = (prime_cnt == CNT_BITS'(PRIME_COUNT));

    for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
        comb_stage #(
            .WIDTH      (DATA_IN_BITS),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (v[k-1]),
            .x         (x[k-1]),
            .out_valid (v[k]),
            .y         (x[k])
        );
    end

    assign data_next = DATA_OUT_BITS'(round_sat(calc_t'($signed(x[NUM_STAGES])),
                                                SHIFT, DATA_OUT_BITS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_out_ready <= 1'b0;
            data_out       <= '0;
        end else begin
            data_out_ready <= v[NUM_STAGES] && ((SUPPRESS_PRIME == 0) || !gate_pipe[NUM_STAGES]);
            if (v[NUM_STAGES])
                data_out <= data_next;
        end
    end

endmodule

// File: tb/tb_cic_comb.sv
// Table-driven bench for cic_comb with a per-instance scoreboard checking value and arrival cycle.
module tb_cic_comb;

    typedef struct {
        int unsigned dut;
        int          din;
        bit          has_out;
        int          exp;
        int unsigned gap;
    } vec_t;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        drdy [4];
    logic [19:0] din  [4];
    logic        ordy [4];
    logic [16:0] dout [4];
    logic        prm  [4];

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    exp_t q [4][$];
    vec_t tbl [$];
    int   lat [4] = '{6, 6, 3, 3};
    int   thr [4] = '{4, 4, 1, 1};
    int   cnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: defaults (N=4, M=1, suppressed), 1: N=4 unsuppressed,
    // 2: N=1 20->17 rounding, 3: N=1 17->17 wrap
    cic_comb u_a (.clk(clk), .rst(rst), .data_in_ready(drdy[0]), .data_in(din[0][16:0]),
                  .data_out_ready(ordy[0]), .data_out(dout[0]), .primed(prm[0]));
    cic_comb #(.NUM_STAGES(4), .DIFF_DELAY(1), .SUPPRESS_PRIME(0)) u_b (
                  .clk(clk), .rst(rst), .data_in_ready(drdy[1]), .data_in(din[1][16:0]),
                  .data_out_ready(ordy[1]), .data_out(dout[1]), .primed(prm[1]));
    cic_comb #(.DATA_IN_BITS(20), .DATA_OUT_BITS(17), .NUM_STAGES(1), .DIFF_DELAY(1),
               .SUPPRESS_PRIME(0)) u_c (
                  .clk(clk), .rst(rst), .data_in_ready(drdy[2]), .data_in(din[2]),
                  .data_out_ready(ordy[2]), .data_out(dout[2]), .primed(prm[2]));
    cic_comb #(.NUM_STAGES(1), .DIFF_DELAY(1), .SUPPRESS_PRIME(0)) u_d (
                  .clk(clk), .rst(rst), .data_in_ready(drdy[3]), .data_in(din[3][16:0]),
                  .data_out_ready(ordy[3]), .data_out(dout[3]), .primed(prm[3]));

    task automatic check_out(input int unsigned i);
        exp_t e;
        int   got;
        got  = int'($signed(dout[i]));
        nvec = nvec + 1;
        if (q[i].size() == 0) begin
            nerr = nerr + 1;
            $display("FAIL unexpected_strobe dut%0d: got data_out=%0d at cycle %0d, required no strobe",
                     i, got, cyc);
        end else begin
            e = q[i].pop_front();
            if (got != e.val || cyc != e.cyc) begin
                nerr = nerr + 1;
                $display("FAIL output dut%0d: got %0d at cycle %0d, required %0d at cycle %0d",
                         i, got, cyc, e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ordy[i] === 1'b1)
                check_out(i);
    end

    task automatic check(input string name, input int got, input int req);
        nvec = nvec + 1;
        if (got != req) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic send(input int unsigned d, input int v, input bit has, input int e);
        drdy[d] = 1'b1;
        din[d]  = 20'(v);
        if (has)
            q[d].push_back('{e, cyc + lat[d]});
        @(negedge clk);
        drdy[d] = 1'b0;
        if (cnt[d] < thr[d])
            cnt[d] = cnt[d] + 1;
    endtask

    task automatic add(input int unsigned d, input int v, input bit has, input int e);
        tbl.push_back('{d, v, has, e, 32});
    endtask

    task automatic run_table();
        for (int n = 0; n < tbl.size(); n++) begin
            send(tbl[n].dut, tbl[n].din, tbl[n].has_out, tbl[n].exp);
            check($sformatf("primed dut%0d vec%0d", tbl[n].dut, n),
                  int'(prm[tbl[n].dut]), (cnt[tbl[n].dut] >= thr[tbl[n].dut]) ? 1 : 0);
            repeat (tbl[n].gap - 1) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            drdy[i] = 1'b0;
            din[i]  = '0;
        end

        // Impulse through 4 combs: binomial 1,-4,6,-4,1
        add(1, 1, 1, 1);  add(1, 0, 1, -4); add(1, 0, 1, 6); add(1, 0, 1, -4);
        add(1, 0, 1, 1);  add(1, 0, 1, 0);  add(1, 0, 1, 0); add(1, 0, 1, 0);
        // Step into suppressed instance: first four outputs gated, rest zero
        add(0, 100, 0, 0); add(0, 100, 0, 0); add(0, 100, 0, 0); add(0, 100, 0, 0);
        add(0, 100, 1, 0); add(0, 100, 1, 0);
        // 17-bit modular wrap
        add(3, 65535, 1, 65535); add(3, -65536, 1, 1);
        // Round half up and positive saturation, 20 -> 17
        add(2, 0, 1, 0); add(2, 'h7FFFF, 1, 65535); add(2, 0, 1, -65536);
        add(2, 12, 1, 2); add(2, 0, 1, -1);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset data_out_ready dut%0d", i), int'(ordy[i]), 0);
            check($sformatf("reset data_out dut%0d", i), int'(dout[i]), 0);
            check($sformatf("reset primed dut%0d", i), int'(prm[i]), 0);
        end

        run_table();

        // Back-to-back impulse on consecutive cycles
        send(1, 1, 1, 1); send(1, 0, 1, -4); send(1, 0, 1, 6); send(1, 0, 1, -4);
        send(1, 0, 1, 1); send(1, 0, 1, 0);  send(1, 0, 1, 0);
        repeat (12) @(negedge clk);

        // Reset with samples in flight; a strobe coincident with the reset cycle is dropped
        send(1, 1, 0, 0);
        send(1, 0, 0, 0);
        send(0, 55, 0, 0);
        rst     = 1'b0;
        drdy[1] = 1'b1;
        din[1]  = 20'd7;
        @(negedge clk);
        rst     = 1'b1;
        drdy[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            cnt[i] = 0;
        end
        repeat (12) @(negedge clk);
        check("post-reset primed dut0", int'(prm[0]), 0);
        check("post-reset primed dut1", int'(prm[1]), 0);
        check("post-reset data_out dut0", int'(dout[0]), 0);
        check("post-reset data_out dut1", int'(dout[1]), 0);

        run_table();

        repeat (20) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            nvec = nvec + 1;
            if (q[i].size() != 0) begin
                nerr = nerr + 1;
                $display("FAIL missing_output dut%0d: got %0d strobes outstanding, required 0",
                         i, q[i].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
